// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial adder: state encodings and default operand width.
package serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StRun  = S_RUN,
        StDone = S_DONE
    } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 3-input full adder built from gate primitives.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic ab;
    logic ac;
    logic bc;

    xor u_xor (s, a, b, c);
    and u_and_ab (ab, a, b);
    and u_and_ac (ac, a, c);
    and u_and_bc (bc, b, c);
    or  u_or_co (co, ab, ac, bc);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
module serial_adder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_s_q, sh_s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic [WIDTH-1:0] sh_s_next;

    full_adder_cell u_fa (
        .a  (sh_a_q[0]),
        .b  (sh_b_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
    if (WIDTH == 1) begin : g_w1
        assign sh_s_next = fa_s;
    end else begin : g_wn
        assign sh_s_next = {fa_s, sh_s_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
        load    = 1'b0;

        case (state_q)
            StIdle: load = start;
            StRun: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                sh_s_d  = sh_s_next;
                carry_d = fa_co;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    state_d = StDone;
                    sum_d   = sh_s_next;
                    cout_d  = fa_co;
                end
            end
            StDone: begin
                state_d = StIdle;
                load    = start;
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StRun;
            sh_a_d  = a;
            sh_b_d  = b;
            carry_d = cin;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
